// File: rtl/serv_bench_timer.sv
// serv_bench_timer: prescaled free-running timer with one compare and a sticky IRQ
// Optional periodic mode: define SERV_BENCH_TIMER_PERIODIC_EN
module serv_bench_timer #(
    parameter int WIDTH   = 32,
    parameter int DIVIDER = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_irq
);
    logic             tick;
    logic             wr;
    logic             match;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] mtime_q, mtime_d;
    logic [WIDTH-1:0] mtimecmp_q, mtimecmp_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic [31:0]      rdt_q;
    logic             unused_ok;
`ifdef SERV_BENCH_TIMER_PERIODIC_EN
    logic [WIDTH-1:0] period_q, period_d;
`endif

    assign wr        = i_wb_cyc & i_wb_we;
    assign wdat      = i_wb_dat[WIDTH-1:0];
    assign match     = armed_q & (mtime_q == mtimecmp_q);
    assign unused_ok = &{1'b0, i_wb_dat};

    generate
        if (DIVIDER == 0) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            logic [DIVIDER-1:0] presc_q;
            // prescaler free-runs and wraps; the counter steps on its last count
            always_ff @(posedge i_clk) begin
                if (i_rst) presc_q <= '0;
                else       presc_q <= presc_q + 1'b1;
            end
            assign tick = &presc_q;
        end
    endgenerate

    // next state: a write always beats a same-cycle match
    always_comb begin
        mtime_d    = mtime_q + WIDTH'(tick);
`ifdef SERV_BENCH_TIMER_PERIODIC_EN
        period_d   = wr ? wdat : period_q;
        mtimecmp_d = wr ? mtime_q + wdat : match ? mtimecmp_q + period_q : mtimecmp_q;
        armed_d    = wr ? (wdat != '0) : armed_q;
        pending_d  = wr ? 1'b0 : match ? 1'b1 : i_wb_cyc ? 1'b0 : pending_q;
`else
        mtimecmp_d = wr ? wdat : mtimecmp_q;
        armed_d    = wr | armed_q;
        pending_d  = wr ? 1'b0 : (match | pending_q);
`endif
    end

    // state and registered read data; read data samples the counter every cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '0;
            armed_q    <= 1'b0;
            pending_q  <= 1'b0;
            rdt_q      <= '0;
`ifdef SERV_BENCH_TIMER_PERIODIC_EN
            period_q   <= '0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            rdt_q      <= 32'(mtime_q);
`ifdef SERV_BENCH_TIMER_PERIODIC_EN
            period_q   <= period_d;
`endif
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_irq    = pending_q;
endmodule
